div_sequencer: RTL

//  Sequences a native iterative radix-2^k restoring divider for RV32M DIV/DIVU/REM/REMU.

---
 rtl/div_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// Sequencer for an iterative radix-2^k restoring divider serving RV32M DIV/DIVU/REM/REMU.
// It resolves the RISC-V special cases without iterating and caches the last Q/R pair.
module div_sequencer #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_opA,
    input  logic [31:0] req_opB,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_data
);
    localparam int N = 32 / BITS_PER_CYCLE;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIXUP, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        uns_q, uns_d, is_rem_q, is_rem_d;
    logic [31:0] mag_b_q, mag_b_d, quo_q, quo_d;
    logic [32:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        cache_valid_q, cache_valid_d, cache_uns_q, cache_uns_d;
    logic [31:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
    logic [31:0] cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;
    logic        busy_q, busy_d, resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;

    logic        accept_s, special_s, hit_s;
    logic [31:0] special_data_s, step_quo_s, fix_quo_s, fix_rem_s;
    logic [32:0] step_rem_s;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            return ~v + 32'd1;
        end else begin
            return v;
        end
    endfunction

    assign req_ready  = (state_q == IDLE) & ~flush;
    assign accept_s   = req_valid & req_ready;
    assign busy       = busy_q | accept_s;
    // A flush landing in the DONE cycle must kill the already-registered pulse.
    assign resp_valid = resp_valid_q & ~flush;
    assign resp_data  = resp_data_q;

    // Special-case detection and cache lookup on the incoming request.
    always_comb begin
        special_s      = 1'b0;
        special_data_s = 32'd0;
        if (req_opB == 32'd0) begin
            special_s      = 1'b1;
            special_data_s = req_op[1] ? req_opA : 32'hFFFF_FFFF;
        end else if (!req_op[0] && req_opA == 32'h8000_0000 && req_opB == 32'hFFFF_FFFF) begin
            special_s      = 1'b1;
            special_data_s = req_op[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            special_s      = 1'b0;
            special_data_s = 32'd0;
        end
        hit_s = cache_valid_q && (cache_a_q == req_opA) && (cache_b_q == req_opB)
                && (cache_uns_q == req_op[0]);
    end

    // BITS_PER_CYCLE shift/subtract/restore steps; quo_q doubles as dividend shifter.
    always_comb begin
        step_rem_s = rem_q;
        step_quo_s = quo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            step_rem_s = {step_rem_s[31:0], step_quo_s[31]};
            step_quo_s = {step_quo_s[30:0], 1'b0};
            if (step_rem_s >= {1'b0, mag_b_q}) begin
                step_rem_s    = step_rem_s - {1'b0, mag_b_q};
                step_quo_s[0] = 1'b1;
            end else begin
                step_quo_s[0] = 1'b0;
            end
        end
    end

    // Sign restoration of the unsigned result pair.
    always_comb begin
        fix_quo_s = (!uns_q && (a_q[31] ^ b_q[31])) ? (~quo_q + 32'd1) : quo_q;
        fix_rem_s = (!uns_q && a_q[31]) ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    end

    // Next-state logic for the sequencer, datapath and cache.
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        uns_d         = uns_q;
        is_rem_d      = is_rem_q;
        mag_b_d       = mag_b_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        cnt_d         = cnt_q;
        cache_valid_d = cache_valid_q;
        cache_uns_d   = cache_uns_q;
        cache_a_d     = cache_a_q;
        cache_b_d     = cache_b_q;
        cache_quo_d   = cache_quo_q;
        cache_rem_d   = cache_rem_q;
        busy_d        = busy_q;
        resp_valid_d  = 1'b0;
        resp_data_d   = 32'd0;
        if (flush) begin
            state_d       = IDLE;
            busy_d        = 1'b0;
            cache_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        a_d      = req_opA;
                        b_d      = req_opB;
                        uns_d    = req_op[0];
                        is_rem_d = req_op[1];
                        busy_d   = 1'b1;
                        if (special_s) begin
                            cache_valid_d = 1'b0;
                            state_d       = DONE;
                            resp_valid_d  = 1'b1;
                            resp_data_d   = special_data_s;
                        end else if (hit_s) begin
                            state_d      = DONE;
                            resp_valid_d = 1'b1;
                            resp_data_d  = req_op[1] ? cache_rem_q : cache_quo_q;
                        end else begin
                            state_d = PREP;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                PREP: begin
                    quo_d   = mag32(a_q, !uns_q);
                    mag_b_d = mag32(b_q, !uns_q);
                    rem_d   = 33'd0;
                    cnt_d   = 5'd0;
                    state_d = CALC;
                end
                CALC: begin
                    quo_d = step_quo_s;
                    rem_d = step_rem_s;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(N - 1)) begin
                        state_d = FIXUP;
                    end else begin
                        state_d = CALC;
                    end
                end
                FIXUP: begin
                    cache_valid_d = 1'b1;
                    cache_uns_d   = uns_q;
                    cache_a_d     = a_q;
                    cache_b_d     = b_q;
                    cache_quo_d   = fix_quo_s;
                    cache_rem_d   = fix_rem_s;
                    state_d       = DONE;
                    resp_valid_d  = 1'b1;
                    resp_data_d   = is_rem_q ? fix_rem_s : fix_quo_s;
                end
                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            uns_q         <= 1'b0;
            is_rem_q      <= 1'b0;
            mag_b_q       <= 32'd0;
            quo_q         <= 32'd0;
            rem_q         <= 33'd0;
            cnt_q         <= 5'd0;
            cache_valid_q <= 1'b0;
            cache_uns_q   <= 1'b0;
            cache_a_q     <= 32'd0;
            cache_b_q     <= 32'd0;
            cache_quo_q   <= 32'd0;
            cache_rem_q   <= 32'd0;
            busy_q        <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            uns_q         <= uns_d;
            is_rem_q      <= is_rem_d;
            mag_b_q       <= mag_b_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
            cnt_q         <= cnt_d;
            cache_valid_q <= cache_valid_d;
            cache_uns_q   <= cache_uns_d;
            cache_a_q     <= cache_a_d;
            cache_b_q     <= cache_b_d;
            cache_quo_q   <= cache_quo_d;
            cache_rem_q   <= cache_rem_d;
            busy_q        <= busy_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
        end
    end
endmodule
